matrix_row_loader: RTL and testbench

MATRIX_ROW_LOADER -- requirements
Module: matrix_row_loader

---
 rtl/mha_pkg.sv | 16 +
 rtl/matrix_row_loader.sv | 76 +++++++
 tb/tb_matrix_row_loader.sv | 250 +++++++++++++++++++++++++
 3 files changed

// File: rtl/mha_pkg.sv
// Shared matrix-stage parameters for the MHA datapath: element width, array
// dimensions and the ping-pong bank index type used by the buffering stages.
package mha_pkg;

  localparam int MHA_D_W    = 8;
  localparam int MHA_SA_R   = 16;
  localparam int MHA_SA_C   = 16;
  localparam int MHA_BANK_W = 1;

  typedef logic [MHA_BANK_W-1:0] bank_idx_t;

  function automatic bank_idx_t other_bank(input bank_idx_t b);
    return ~b;
  endfunction

endpackage

// File: rtl/matrix_row_loader.sv
// Collects SA_R row beats into a ping-pong pair of matrix banks: one bank fills
// from the row stream while the other is presented whole to the add stage.
module matrix_row_loader
  import mha_pkg::*;
#(
  parameter  int D_W   = MHA_D_W,
  parameter  int SA_R  = MHA_SA_R,
  parameter  int SA_C  = MHA_SA_C,
  localparam int CNT_W = (SA_R > 1) ? $clog2(SA_R) : 1
) (
  input  logic             I_CLK,
  input  logic             I_RST,
  input  logic             I_ROW_VLD,
  output logic             O_ROW_RDY,
  input  logic [D_W-1:0]   I_ROW_DATA [0:SA_C-1],
  output logic             O_MAT_VLD,
  input  logic             I_MAT_RDY,
  output logic [D_W-1:0]   O_MAT [0:SA_R-1][0:SA_C-1],
  output logic [CNT_W-1:0] O_ROW_CNT
);

  logic [D_W-1:0]   r_bank [0:1][0:SA_R-1][0:SA_C-1];
  logic [1:0]       r_full;
  bank_idx_t        r_wr_bank;
  bank_idx_t        r_rd_bank;
  logic [CNT_W-1:0] r_row_cnt;

  logic w_accept;
  logic w_release;
  logic w_last_row;

  // Handshakes depend only on registered state, so ready never loops back
  // through the upstream valid.
  assign O_ROW_RDY  = !r_full[r_wr_bank];
  assign O_MAT_VLD  = r_full[r_rd_bank];
  assign O_ROW_CNT  = r_row_cnt;
  assign O_MAT      = r_bank[r_rd_bank];

  assign w_accept   = I_ROW_VLD && O_ROW_RDY;
  assign w_release  = O_MAT_VLD && I_MAT_RDY;
  assign w_last_row = (r_row_cnt == CNT_W'(SA_R - 1));

  // Accept and release always touch different banks (one is empty, the other
  // full), so both updates to r_full can land on the same edge.
  always_ff @(posedge I_CLK) begin
    if (I_RST) begin
      r_full    <= '0;
      r_wr_bank <= '0;
      r_rd_bank <= '0;
      r_row_cnt <= '0;
    end else begin
      if (w_accept) begin
        if (w_last_row) begin
          r_full[r_wr_bank] <= 1'b1;
          r_wr_bank         <= other_bank(r_wr_bank);
          r_row_cnt         <= '0;
        end else begin
          r_row_cnt <= r_row_cnt + CNT_W'(1);
        end
      end
      if (w_release) begin
        r_full[r_rd_bank] <= 1'b0;
        r_rd_bank         <= other_bank(r_rd_bank);
      end
    end
  end

  // NOTE: bank storage has no reset; the full flags already mark every bank
  // empty, and resetting a flop array this wide only costs reset fan-out.
  always_ff @(posedge I_CLK) begin
    if (!I_RST && w_accept) begin
      r_bank[r_wr_bank][r_row_cnt] <= I_ROW_DATA;
    end
  end

endmodule

// File: tb/tb_matrix_row_loader.sv
// Directed and random checks of the ping-pong matrix row loader against a
// row-stream model and a scoreboard of completed matrices.
module tb_matrix_row_loader;
  import mha_pkg::*;

  localparam int D_W  = 8;
  localparam int SA_R = 16;
  localparam int SA_C = 16;

  logic           I_CLK;
  logic           I_RST;
  logic           I_ROW_VLD;
  logic           I_MAT_RDY;
  logic           O_ROW_RDY;
  logic           O_MAT_VLD;
  logic [D_W-1:0] row_data [0:SA_C-1];
  logic [D_W-1:0] mat      [0:SA_R-1][0:SA_C-1];
  logic [3:0]     row_cnt;

  int checks   = 0;
  int errors   = 0;
  int cur_mat  = 0;
  int cur_row  = 0;
  bit a5_mode  = 1'b0;
  int q[$];
  int accepts  = 0;
  int releases = 0;
  int pushes   = 0;
  int rdy_low  = 0;
  bit m_acc, m_rel, m_rst;

  matrix_row_loader #(.D_W(D_W), .SA_R(SA_R), .SA_C(SA_C)) dut (
    .I_CLK      (I_CLK),
    .I_RST      (I_RST),
    .I_ROW_VLD  (I_ROW_VLD),
    .O_ROW_RDY  (O_ROW_RDY),
    .I_ROW_DATA (row_data),
    .O_MAT_VLD  (O_MAT_VLD),
    .I_MAT_RDY  (I_MAT_RDY),
    .O_MAT      (mat),
    .O_ROW_CNT  (row_cnt)
  );

  initial I_CLK = 1'b0;
  always #5 I_CLK = ~I_CLK;

  // Matrix id 0 gives element r*16+c; id -1 is the all-0xA5 matrix.
  function automatic logic [7:0] elem(input int id, input int r, input int c);
    if (id < 0) return 8'hA5;
    return 8'(id * 37 + r * 16 + c);
  endfunction

  always_comb begin
    for (int c = 0; c < SA_C; c++) begin
      row_data[c] = elem(a5_mode ? -1 : cur_mat, cur_row, c);
    end
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic check_release();
    int id, bad, br, bc;
    releases++;
    check("release_has_matrix", q.size() > 0, 1);
    if (q.size() > 0) begin
      id = q.pop_front();
      bad = 0; br = 0; bc = 0;
      for (int r = 0; r < SA_R; r++) begin
        for (int c = 0; c < SA_C; c++) begin
          if (mat[r][c] !== elem(id, r, c)) begin
            if (bad == 0) begin
              br = r;
              bc = c;
            end
            bad++;
          end
        end
      end
      check($sformatf("matrix_%0d_r%0d_c%0d", id, br, bc), 32'(mat[br][bc]), 32'(elem(id, br, bc)));
    end
  endtask

  // Handshakes are decided at the falling edge; the row model advances just
  // after the rising edge that commits them.
  always begin
    @(negedge I_CLK);
    m_rst = I_RST;
    m_acc = I_ROW_VLD && O_ROW_RDY && !I_RST;
    m_rel = O_MAT_VLD && I_MAT_RDY && !I_RST;
    if (I_ROW_VLD && !O_ROW_RDY && !m_rst) rdy_low++;
    if (m_rel) check_release();
    @(posedge I_CLK);
    #2;
    if (m_rst) begin
      cur_row = 0;
      q.delete();
    end else if (m_acc) begin
      accepts++;
      if (cur_row == SA_R - 1) begin
        q.push_back(a5_mode ? -1 : cur_mat);
        pushes++;
        cur_row = 0;
        if (!a5_mode) cur_mat++;
      end else begin
        cur_row++;
      end
    end
  end

  task automatic tick();
    @(posedge I_CLK);
    #3;
  endtask

  task automatic drain(input string tag);
    I_ROW_VLD = 1'b0;
    I_MAT_RDY = 1'b1;
    for (int i = 0; i < 200 && (q.size() != 0 || O_MAT_VLD); i++) tick();
    check(tag, q.size(), 0);
    I_MAT_RDY = 1'b0;
  endtask

  initial begin
    int k, base, rbase, lbase, target;
    I_RST     = 1'b1;
    I_ROW_VLD = 1'b0;
    I_MAT_RDY = 1'b0;
    tick();
    tick();
    I_RST = 1'b0;
    check("reset_mat_vld", O_MAT_VLD, 0);
    check("reset_row_rdy", O_ROW_RDY, 1);
    check("reset_row_cnt", row_cnt, 0);

    // One ramp matrix with the consumer always ready.
    rbase = releases;
    I_MAT_RDY = 1'b1;
    I_ROW_VLD = 1'b1;
    repeat (5) tick();
    check("t1_row_cnt_5", row_cnt, 5);
    repeat (11) tick();
    I_ROW_VLD = 1'b0;
    check("t1_mat_vld_after_last", O_MAT_VLD, 1);
    check("t1_row_cnt_wrap", row_cnt, 0);
    check("t1_sample_r7_c9", mat[7][9], 8'd121);
    tick();
    check("t1_released", releases - rbase, 1);
    check("t1_mat_vld_clear", O_MAT_VLD, 0);

    // Back-pressure: both banks fill, then the consumer drains in order.
    k = cur_mat;
    base = accepts;
    rbase = releases;
    I_MAT_RDY = 1'b0;
    I_ROW_VLD = 1'b1;
    repeat (32) tick();
    check("t2_rdy_low_both_full", O_ROW_RDY, 0);
    check("t2_mat_vld", O_MAT_VLD, 1);
    check("t2_accepts_32", accepts - base, 32);
    check("t2_row_cnt_hold", row_cnt, 0);
    repeat (5) tick();
    check("t2_held_value", mat[3][5], elem(k, 3, 5));
    check("t2_held_vld", O_MAT_VLD, 1);
    check("t2_no_extra_accepts", accepts - base, 32);
    I_MAT_RDY = 1'b1;
    check("t2_rdy_before_release", O_ROW_RDY, 0);
    tick();
    check("t2_rdy_after_release", O_ROW_RDY, 1);
    check("t2_second_matrix", mat[0][0], elem(k + 1, 0, 0));
    check("t2_accepts_still_32", accepts - base, 32);
    tick();
    check("t2_row32_accepted", accepts - base, 33);
    for (int i = 0; i < 100 && accepts - base < 48; i++) tick();
    I_ROW_VLD = 1'b0;
    check("t2_accepts_48", accepts - base, 48);
    drain("t2_drain");
    check("t2_releases_3", releases - rbase, 3);

    // Sustained streaming with the consumer always ready.
    base = accepts;
    rbase = releases;
    lbase = rdy_low;
    I_MAT_RDY = 1'b1;
    I_ROW_VLD = 1'b1;
    repeat (64) tick();
    I_ROW_VLD = 1'b0;
    check("t3_accepts_64", accepts - base, 64);
    check("t3_rdy_never_low", rdy_low - lbase, 0);
    drain("t3_drain");
    check("t3_releases_4", releases - rbase, 4);

    // Release coinciding with the final row of the other bank.
    k = cur_mat;
    I_MAT_RDY = 1'b0;
    I_ROW_VLD = 1'b1;
    repeat (31) tick();
    check("t4_row_cnt_15", row_cnt, 15);
    check("t4_first_shown", mat[0][1], elem(k, 0, 1));
    I_MAT_RDY = 1'b1;
    tick();
    I_MAT_RDY = 1'b0;
    I_ROW_VLD = 1'b0;
    check("t4_vld_stays", O_MAT_VLD, 1);
    check("t4_switch_to_new", mat[15][15], elem(k + 1, 15, 15));
    check("t4_rdy_free", O_ROW_RDY, 1);
    drain("t4_drain");

    // Reset mid-fill discards the partial matrix.
    I_ROW_VLD = 1'b1;
    repeat (7) tick();
    check("t5_row_cnt_7", row_cnt, 7);
    I_RST = 1'b1;
    tick();
    I_RST = 1'b0;
    I_ROW_VLD = 1'b0;
    check("t5_rst_row_cnt", row_cnt, 0);
    check("t5_rst_mat_vld", O_MAT_VLD, 0);
    check("t5_rst_row_rdy", O_ROW_RDY, 1);
    a5_mode = 1'b1;
    I_ROW_VLD = 1'b1;
    repeat (16) tick();
    I_ROW_VLD = 1'b0;
    check("t5_a5_vld", O_MAT_VLD, 1);
    check("t5_a5_sample", mat[9][4], 8'hA5);
    drain("t5_drain");
    a5_mode = 1'b0;

    // Random valid/ready traffic for 1000 matrices.
    target = cur_mat + 1000;
    for (int i = 0; i < 60000 && cur_mat < target; i++) begin
      I_ROW_VLD = ($urandom_range(0, 3) != 0);
      I_MAT_RDY = ($urandom_range(0, 1) != 0);
      tick();
    end
    I_ROW_VLD = 1'b0;
    check("t6_matrices_done", cur_mat, target);
    drain("t6_drain");
    check("total_release_count", releases, pushes);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
